// File: rtl/pending8_arbiter.sv
// Sticky 8-channel event latch with a single-grant valid/ready arbiter.
// Event pulses on req are held in pending until their channel is granted
// and accepted. A second event that arrives while a channel is already
// pending is recorded in overflow.
//
// state | meaning
// IDLE  | no grant offered; pick a winner when pending is non-zero
// OFFER | grant_id/grant_onehot held stable until grant_ready
module pending8_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       grant_ready,
  input  logic       clr_overflow,
  output logic [7:0] pending,
  output logic       grant_valid,
  output logic [2:0] grant_id,
  output logic [7:0] grant_onehot,
  output logic [7:0] overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state;
  state_t     state_next;
  logic       load_grant;
  logic       handshake;
  logic [7:0] clear_vec;
  logic [7:0] overflow_set;
  logic [2:0] ptr;
  logic [2:0] win_id;
  logic [2:0] idx;
  logic       win_found;

  assign handshake    = (state == OFFER) && grant_ready;
  assign clear_vec    = handshake ? (8'b1 << grant_id) : 8'b0;
  assign overflow_set = req & pending & ~clear_vec;
  assign grant_valid  = (state == OFFER);
  assign grant_onehot = grant_valid ? (8'b1 << grant_id) : 8'b0;

  // Winner search: from ptr with wrap-around, or from channel 0 when fixed.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    idx       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = ROUND_ROBIN ? (ptr + 3'(k)) : 3'(k);
      if (!win_found && pending[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state; the winner is only captured on the IDLE->OFFER edge.
  always_comb begin
    state_next = state;
    load_grant = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_next = OFFER;
          load_grant = 1'b1;
        end
      end
      OFFER: begin
        if (grant_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant id and rotation pointer; ptr moves past each accepted grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id <= 3'd0;
      ptr      <= 3'd0;
    end else begin
      if (load_grant) grant_id <= win_id;
      if (handshake)  ptr      <= grant_id + 3'd1;
    end
  end

  // Pending and overflow; a new event beats a same-cycle clear or clr_overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 8'b0;
      overflow <= 8'b0;
    end else begin
      pending  <= req | (pending & ~clear_vec);
      overflow <= overflow_set | (clr_overflow ? 8'b0 : overflow);
    end
  end

endmodule

// File: tb/tb_pending8_arbiter.sv
// Scenario bench for pending8_arbiter. Expected grant ids are queued when
// events are driven and popped when the matching grant is offered. A second
// instance with fixed priority shares the inputs.
module tb_pending8_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       grant_ready;
  logic       clr_overflow;
  logic [7:0] pending, grant_onehot, overflow;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic [7:0] pending_fp, grant_onehot_fp, overflow_fp;
  logic       grant_valid_fp;
  logic [2:0] grant_id_fp;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int exp_fp_q[$];

  always #5 clk = ~clk;

  pending8_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req), .grant_ready(grant_ready),
    .clr_overflow(clr_overflow), .pending(pending), .grant_valid(grant_valid),
    .grant_id(grant_id), .grant_onehot(grant_onehot), .overflow(overflow)
  );

  pending8_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .req(req), .grant_ready(grant_ready),
    .clr_overflow(clr_overflow), .pending(pending_fp), .grant_valid(grant_valid_fp),
    .grant_id(grant_id_fp), .grant_onehot(grant_onehot_fp), .overflow(overflow_fp)
  );

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -1;
    return exp_q.pop_front();
  endfunction

  function automatic int pop_exp_fp();
    if (exp_fp_q.size() == 0) return -1;
    return exp_fp_q.pop_front();
  endfunction

  // Waits (bounded) at negedges until the round-robin instance offers a grant.
  task automatic wait_valid(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      if (grant_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = 8'h00; grant_ready = 1'b0; clr_overflow = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_fp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req = 8'hFF; grant_ready = 1'b1; clr_overflow = 1'b1;
    @(negedge clk);
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending got=%h exp=00", pending); end
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL reset_overflow got=%h exp=00", overflow); end
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", grant_valid); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", grant_id); end
    n_checks++; if (grant_onehot !== 8'h00) begin n_fail++; $display("FAIL reset_onehot got=%h exp=00", grant_onehot); end
    reset = 1'b0; req = 8'h00; grant_ready = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic test_single_event();
    int e;
    do_reset();
    req = 8'h04; grant_ready = 1'b1; exp_q.push_back(2);
    @(negedge clk);
    req = 8'h00;
    n_checks++; if (pending !== 8'h04) begin n_fail++; $display("FAIL single_pending got=%h exp=04", pending); end
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early got=%b exp=0", grant_valid); end
    @(negedge clk);
    e = pop_exp();
    n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", grant_valid); end
    n_checks++; if (int'(grant_id) !== e) begin n_fail++; $display("FAIL single_id got=%0d exp=%0d", grant_id, e); end
    n_checks++; if (grant_onehot !== 8'h04) begin n_fail++; $display("FAIL single_onehot got=%h exp=04", grant_onehot); end
    @(negedge clk);
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL single_pending_after got=%h exp=00", pending); end
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after got=%b exp=0", grant_valid); end
  endtask

  task automatic test_rr_drain();
    bit ok;
    int waited, e, n;
    logic [7:0] pend_m, oh;
    do_reset();
    grant_ready = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 0) begin
        req = 8'hFF; pend_m = 8'hFF; n = 8;
        for (int g = 0; g < 8; g++) exp_q.push_back(g);
      end else begin
        req = 8'h81; pend_m = 8'h81; n = 2;
        exp_q.push_back(0); exp_q.push_back(7);
      end
      @(negedge clk);
      req = 8'h00;
      for (int i = 0; i < n; i++) begin
        wait_valid(ok, waited);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_timeout got=no_grant exp=grant"); end
        n_checks++; if (waited !== 1) begin n_fail++; $display("FAIL rr_spacing got=%0d exp=1", waited); end
        e = pop_exp();
        oh = 8'b1 << e;
        n_checks++; if (int'(grant_id) !== e) begin n_fail++; $display("FAIL rr_id got=%0d exp=%0d", grant_id, e); end
        n_checks++; if (grant_onehot !== oh) begin n_fail++; $display("FAIL rr_onehot got=%h exp=%h", grant_onehot, oh); end
        n_checks++; if (pending !== pend_m) begin n_fail++; $display("FAIL rr_pending_offer got=%h exp=%h", pending, pend_m); end
        pend_m = pend_m & ~oh;
        @(negedge clk);
        n_checks++; if (pending !== pend_m) begin n_fail++; $display("FAIL rr_pending_after got=%h exp=%h", pending, pend_m); end
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle_gap got=%b exp=0", grant_valid); end
      end
    end
    grant_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int waited, e;
    do_reset();
    req = 8'h08; exp_q.push_back(3);
    @(negedge clk);
    req = 8'h00;
    wait_valid(ok, waited);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got=no_grant exp=grant"); end
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (grant_valid !== 1'b1 || grant_id !== 3'd3) begin n_fail++; $display("FAIL bp_hold got=%b/%0d exp=1/3", grant_valid, grant_id); end
      req = (c == 1) ? 8'h10 : 8'h00;
      @(negedge clk);
    end
    req = 8'h00;
    n_checks++; if (pending !== 8'h18) begin n_fail++; $display("FAIL bp_pending got=%h exp=18", pending); end
    grant_ready = 1'b1;
    e = pop_exp();
    n_checks++; if (int'(grant_id) !== e) begin n_fail++; $display("FAIL bp_id got=%0d exp=%0d", grant_id, e); end
    @(negedge clk);
    n_checks++; if (pending !== 8'h10 || grant_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after got=%h/%b exp=10/0", pending, grant_valid); end
    exp_q.push_back(4);
    wait_valid(ok, waited);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout2 got=no_grant exp=grant"); end
    e = pop_exp();
    n_checks++; if (int'(grant_id) !== e) begin n_fail++; $display("FAIL bp_next_id got=%0d exp=%0d", grant_id, e); end
    @(negedge clk);
    grant_ready = 1'b0;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL bp_drained got=%h exp=00", pending); end
  endtask

  task automatic test_overflow();
    bit ok;
    int waited, e;
    do_reset();
    req = 8'h08; exp_q.push_back(3);
    @(negedge clk);
    req = 8'h00;
    n_checks++; if (pending !== 8'h08 || overflow !== 8'h00) begin n_fail++; $display("FAIL ov_start got=%h/%h exp=08/00", pending, overflow); end
    for (int p = 0; p < 2; p++) begin
      req = 8'h08;
      @(negedge clk);
      req = 8'h00;
      n_checks++; if (overflow !== 8'h08) begin n_fail++; $display("FAIL ov_set got=%h exp=08", overflow); end
    end
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL ov_clear got=%h exp=00", overflow); end
    req = 8'h08; clr_overflow = 1'b1;
    @(negedge clk);
    req = 8'h00; clr_overflow = 1'b0;
    n_checks++; if (overflow !== 8'h08) begin n_fail++; $display("FAIL ov_set_wins got=%h exp=08", overflow); end
    n_checks++; if (pending !== 8'h08) begin n_fail++; $display("FAIL ov_pending got=%h exp=08", pending); end
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL ov_clear2 got=%h exp=00", overflow); end
    wait_valid(ok, waited);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ov_timeout got=no_grant exp=grant"); end
    grant_ready = 1'b1;
    e = pop_exp();
    n_checks++; if (int'(grant_id) !== e) begin n_fail++; $display("FAIL ov_id got=%0d exp=%0d", grant_id, e); end
    @(negedge clk);
    grant_ready = 1'b0;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL ov_drained got=%h exp=00", pending); end
  endtask

  task automatic test_rerequest();
    bit ok;
    int waited, e;
    do_reset();
    req = 8'h20; exp_q.push_back(5);
    @(negedge clk);
    req = 8'h00;
    wait_valid(ok, waited);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rereq_timeout got=no_grant exp=grant"); end
    e = pop_exp();
    n_checks++; if (int'(grant_id) !== e) begin n_fail++; $display("FAIL rereq_first got=%0d exp=%0d", grant_id, e); end
    grant_ready = 1'b1; req = 8'h21;
    exp_q.push_back(0); exp_q.push_back(5);
    @(negedge clk);
    req = 8'h00;
    n_checks++; if (pending !== 8'h21) begin n_fail++; $display("FAIL rereq_pending got=%h exp=21", pending); end
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL rereq_overflow got=%h exp=00", overflow); end
    for (int i = 0; i < 2; i++) begin
      wait_valid(ok, waited);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rereq_timeout2 got=no_grant exp=grant"); end
      e = pop_exp();
      n_checks++; if (int'(grant_id) !== e) begin n_fail++; $display("FAIL rereq_order got=%0d exp=%0d", grant_id, e); end
      @(negedge clk);
    end
    grant_ready = 1'b0;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL rereq_drained got=%h exp=00", pending); end
  endtask

  task automatic test_reset_mid_offer();
    bit ok;
    int waited;
    do_reset();
    req = 8'h04;
    @(negedge clk);
    req = 8'h04;
    @(negedge clk);
    req = 8'h00;
    wait_valid(ok, waited);
    n_checks++; if (!ok || overflow !== 8'h04) begin n_fail++; $display("FAIL rst_mid_setup got=%b/%h exp=1/04", ok, overflow); end
    reset = 1'b1; req = 8'hFF; grant_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (grant_valid !== 1'b0 || grant_id !== 3'd0 || grant_onehot !== 8'h00) begin n_fail++; $display("FAIL rst_mid_grant got=%b/%0d/%h exp=0/0/00", grant_valid, grant_id, grant_onehot); end
    n_checks++; if (pending !== 8'h00 || overflow !== 8'h00) begin n_fail++; $display("FAIL rst_mid_state got=%h/%h exp=00/00", pending, overflow); end
    reset = 1'b0; req = 8'h00; grant_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet got=%b exp=0", grant_valid); end
  endtask

  task automatic test_fixed_priority();
    bit ok;
    int waited, e, ef;
    do_reset();
    grant_ready = 1'b1;
    req = 8'h02; exp_q.push_back(1); exp_fp_q.push_back(1);
    @(negedge clk);
    req = 8'h00;
    for (int rep = 0; rep < 4; rep++) begin
      if (rep > 0) begin
        req = 8'h81;
        exp_q.push_back(7); exp_q.push_back(0);
        exp_fp_q.push_back(0); exp_fp_q.push_back(7);
        @(negedge clk);
        req = 8'h00;
      end
      for (int i = 0; i < ((rep == 0) ? 1 : 2); i++) begin
        wait_valid(ok, waited);
        n_checks++; if (!ok || grant_valid_fp !== 1'b1) begin n_fail++; $display("FAIL fp_timeout got=%b/%b exp=1/1", ok, grant_valid_fp); end
        e  = pop_exp();
        ef = pop_exp_fp();
        n_checks++; if (int'(grant_id_fp) !== ef) begin n_fail++; $display("FAIL fp_id got=%0d exp=%0d", grant_id_fp, ef); end
        n_checks++; if (int'(grant_id) !== e) begin n_fail++; $display("FAIL fp_rr_id got=%0d exp=%0d", grant_id, e); end
        @(negedge clk);
      end
    end
    grant_ready = 1'b0;
    n_checks++; if (pending_fp !== 8'h00) begin n_fail++; $display("FAIL fp_drained got=%h exp=00", pending_fp); end
  endtask

  initial begin
    reset = 1'b1; req = 8'h00; grant_ready = 1'b0; clr_overflow = 1'b0;
    test_reset();
    test_single_event();
    test_rr_drain();
    test_backpressure();
    test_overflow();
    test_rerequest();
    test_reset_mid_offer();
    test_fixed_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
